// File: rtl/mem_issue_queue_pkg.sv
// Shared types for the in-order load/store issue queue: queue entry, issue bundle, FSM state.
package mem_issue_queue_pkg;

  localparam int unsigned RobIdxW = 5;

  typedef enum logic [1:0] {MQ_IDLE, MQ_WAIT_LOAD, MQ_DRAIN} mem_q_state_t;

  typedef enum logic {MemopLoad = 1'b0, MemopStore = 1'b1} memop_t;

  typedef struct packed {
    logic               ready;
    logic [RobIdxW-1:0] tag;
    logic [31:0]        data;
  } mem_q_operand_t;

  typedef struct packed {
    logic               valid;
    logic [31:0]        pc;
    logic [31:0]        inst;
    logic [4:0]         rd_addr;
    logic [4:0]         rs1_addr;
    logic [4:0]         rs2_addr;
    logic [RobIdxW-1:0] rd_rob_idx;
    logic [31:0]        imm_sext;
    memop_t             memop;
    logic [3:0]         mem_rmask;
    logic [3:0]         mem_wmask;
    mem_q_operand_t     rs1;
    mem_q_operand_t     rs2;
  } mem_q_entry_t;

  typedef struct packed {
    logic               valid;
    logic [31:0]        pc;
    logic [31:0]        inst;
    logic [4:0]         rd_addr;
    logic [4:0]         rs1_addr;
    logic [4:0]         rs2_addr;
    logic [RobIdxW-1:0] rd_rob_idx;
    logic [RobIdxW-1:0] rs1_tag;
    logic [RobIdxW-1:0] rs2_tag;
    logic [31:0]        rs1_data;
    logic [31:0]        rs2_data;
    logic [31:0]        imm;
    memop_t             memop;
    logic [3:0]         mem_rmask;
    logic [3:0]         mem_wmask;
  } reservation_station_t;

  function automatic reservation_station_t mq_to_bundle(input mem_q_entry_t e);
    reservation_station_t b;
    b.valid      = 1'b1;
    b.pc         = e.pc;
    b.inst       = e.inst;
    b.rd_addr    = e.rd_addr;
    b.rs1_addr   = e.rs1_addr;
    b.rs2_addr   = e.rs2_addr;
    b.rd_rob_idx = e.rd_rob_idx;
    b.rs1_tag    = e.rs1.tag;
    b.rs2_tag    = e.rs2.tag;
    b.rs1_data   = e.rs1.data;
    b.rs2_data   = e.rs2.data;
    b.imm        = e.imm_sext;
    b.memop      = e.memop;
    b.mem_rmask  = e.mem_rmask;
    b.mem_wmask  = e.mem_wmask;
    return b;
  endfunction

endpackage

// File: rtl/mem_issue_queue_operand_capture.sv
// Combinational CDB snoop for one pending source operand.
module mem_q_operand_capture
  import mem_issue_queue_pkg::*;
(
  input  logic               entry_valid_i,
  input  mem_q_operand_t     op_i,
  input  logic               cdb_valid_i,
  input  logic [RobIdxW-1:0] cdb_rob_idx_i,
  input  logic [31:0]        cdb_data_i,
  output mem_q_operand_t     op_o
);

  always_comb begin
    op_o = op_i;
    if (entry_valid_i && !op_i.ready && cdb_valid_i && (op_i.tag == cdb_rob_idx_i)) begin
      op_o.ready = 1'b1;
      op_o.data  = cdb_data_i;
    end
  end

endmodule

// File: rtl/mem_issue_queue.sv
// In-order load/store issue queue with CDB operand capture and a held issue bundle.
// Define MEM_ISSUE_QUEUE_STORE_COMMIT_EN to hold stores at head until they reach ROB head.
module mem_issue_queue
  import mem_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned ROB_IDX_W = RobIdxW
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         enq_valid,
  output logic                         enq_ready,
  input  mem_q_entry_t                 enq_entry,
  input  logic                         cdb_valid,
  input  logic [ROB_IDX_W-1:0]         cdb_rob_idx,
  input  logic [31:0]                  cdb_data,
  input  logic [ROB_IDX_W-1:0]         rob_head_idx,
  input  logic                         mem_done,
  output logic                         issue_valid,
  output reservation_station_t         issue_bundle,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned PtrW = IdxW + 1;

  mem_q_state_t         state_q, state_d;
  logic [PtrW-1:0]      head_q, head_d, tail_q, tail_d;
  mem_q_entry_t         entries_q [DEPTH];
  mem_q_entry_t         entries_d [DEPTH];
  mem_q_operand_t       rs1_cap [DEPTH];
  mem_q_operand_t       rs2_cap [DEPTH];
  mem_q_operand_t       enq_rs1_cap, enq_rs2_cap;
  reservation_station_t issue_bundle_q;
  logic                 issue_valid_q;

  logic         empty, full, pop, enq_fire, head_go, store_commit_ok;
  mem_q_entry_t head_entry;

  for (genvar i = 0; i < DEPTH; i++) begin : g_cap
    mem_q_operand_capture u_rs1 (
      .entry_valid_i (entries_q[i].valid),
      .op_i          (entries_q[i].rs1),
      .cdb_valid_i   (cdb_valid),
      .cdb_rob_idx_i (cdb_rob_idx),
      .cdb_data_i    (cdb_data),
      .op_o          (rs1_cap[i])
    );
    mem_q_operand_capture u_rs2 (
      .entry_valid_i (entries_q[i].valid),
      .op_i          (entries_q[i].rs2),
      .cdb_valid_i   (cdb_valid),
      .cdb_rob_idx_i (cdb_rob_idx),
      .cdb_data_i    (cdb_data),
      .op_o          (rs2_cap[i])
    );
  end

  // A producer broadcasting in the enqueue cycle must not be missed.
  mem_q_operand_capture u_enq_rs1 (
    .entry_valid_i (enq_valid),
    .op_i          (enq_entry.rs1),
    .cdb_valid_i   (cdb_valid),
    .cdb_rob_idx_i (cdb_rob_idx),
    .cdb_data_i    (cdb_data),
    .op_o          (enq_rs1_cap)
  );
  mem_q_operand_capture u_enq_rs2 (
    .entry_valid_i (enq_valid),
    .op_i          (enq_entry.rs2),
    .cdb_valid_i   (cdb_valid),
    .cdb_rob_idx_i (cdb_rob_idx),
    .cdb_data_i    (cdb_data),
    .op_o          (enq_rs2_cap)
  );

  assign empty      = (head_q == tail_q);
  assign full       = (head_q[IdxW-1:0] == tail_q[IdxW-1:0]) && (head_q[IdxW] != tail_q[IdxW]);
  assign count      = tail_q - head_q;
  assign head_entry = entries_q[head_q[IdxW-1:0]];
  assign enq_fire   = enq_valid && enq_ready;

`ifdef MEM_ISSUE_QUEUE_STORE_COMMIT_EN
  assign store_commit_ok = (head_entry.rd_rob_idx == rob_head_idx);
`else
  logic unused_rob_head;
  assign unused_rob_head = ^rob_head_idx;
  assign store_commit_ok = 1'b1;
`endif

  assign head_go = !empty && head_entry.valid && head_entry.rs1.ready &&
                   ((head_entry.memop == MemopLoad) || (head_entry.rs2.ready && store_commit_ok));

  always_ff @(posedge clk) begin
    if (rst) state_q <= MQ_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MQ_IDLE: begin
        if (pop && head_entry.memop == MemopLoad) state_d = MQ_WAIT_LOAD;
      end
      MQ_WAIT_LOAD: begin
        if (mem_done) begin
          state_d = (pop && head_entry.memop == MemopLoad) ? MQ_WAIT_LOAD : MQ_IDLE;
        end else if (flush) begin
          state_d = MQ_DRAIN;
        end
      end
      MQ_DRAIN: begin
        if (mem_done) state_d = MQ_IDLE;
      end
      default: state_d = MQ_IDLE;
    endcase
  end

  always_comb begin
    enq_ready = !full && !flush && (state_q != MQ_DRAIN);
    pop       = 1'b0;
    unique case (state_q)
      MQ_IDLE:      pop = head_go;
      MQ_WAIT_LOAD: pop = mem_done && head_go;
      default:      pop = 1'b0;
    endcase
    if (flush) pop = 1'b0;
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      entries_d[i]     = entries_q[i];
      entries_d[i].rs1 = rs1_cap[i];
      entries_d[i].rs2 = rs2_cap[i];
    end
    if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) entries_d[i].valid = 1'b0;
      head_d = '0;
      tail_d = '0;
    end else begin
      if (pop) begin
        entries_d[head_q[IdxW-1:0]].valid = 1'b0;
        head_d = head_q + PtrW'(1);
      end
      if (enq_fire) begin
        entries_d[tail_q[IdxW-1:0]]       = enq_entry;
        entries_d[tail_q[IdxW-1:0]].valid = 1'b1;
        entries_d[tail_q[IdxW-1:0]].rs1   = enq_rs1_cap;
        entries_d[tail_q[IdxW-1:0]].rs2   = enq_rs2_cap;
        tail_d = tail_q + PtrW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      issue_valid_q  <= 1'b0;
      issue_bundle_q <= '0;
    end else begin
      entries_q     <= entries_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      issue_valid_q <= pop;
      // The memory unit reads the bundle until mem_done, so an outstanding load keeps it.
      if (pop) begin
        issue_bundle_q <= mq_to_bundle(head_entry);
      end else if (flush && state_q == MQ_IDLE) begin
        issue_bundle_q.valid <= 1'b0;
      end else if (state_q == MQ_DRAIN && mem_done) begin
        issue_bundle_q.valid <= 1'b0;
      end
    end
  end

  assign issue_valid  = issue_valid_q;
  assign issue_bundle = issue_bundle_q;

endmodule

// File: tb/tb_mem_issue_queue.sv
// Scoreboard bench for mem_issue_queue: directed enqueues push expected issues, a monitor checks.
module tb_mem_issue_queue;
  import mem_issue_queue_pkg::*;

  localparam int unsigned Depth = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 flush = 1'b0;
  logic                 enq_valid = 1'b0;
  logic                 enq_ready;
  mem_q_entry_t         enq_entry = '0;
  logic                 cdb_valid = 1'b0;
  logic [RobIdxW-1:0]   cdb_rob_idx = '0;
  logic [31:0]          cdb_data = '0;
  logic [RobIdxW-1:0]   rob_head_idx = 5'd9;
  logic                 mem_done = 1'b0;
  logic                 issue_valid;
  reservation_station_t issue_bundle;
  logic [3:0]           count;

  mem_issue_queue #(.DEPTH(Depth), .ROB_IDX_W(RobIdxW)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .enq_valid    (enq_valid),
    .enq_ready    (enq_ready),
    .enq_entry    (enq_entry),
    .cdb_valid    (cdb_valid),
    .cdb_rob_idx  (cdb_rob_idx),
    .cdb_data     (cdb_data),
    .rob_head_idx (rob_head_idx),
    .mem_done     (mem_done),
    .issue_valid  (issue_valid),
    .issue_bundle (issue_bundle),
    .count        (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        st;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic mem_q_entry_t mk(input logic [31:0] pc, input logic st,
                                      input logic r1, input logic [4:0] t1, input logic [31:0] d1,
                                      input logic r2, input logic [4:0] t2, input logic [31:0] d2,
                                      input logic [4:0] rob);
    mem_q_entry_t e;
    e            = '0;
    e.valid      = 1'b1;
    e.pc         = pc;
    e.inst       = 32'h0000_2003;
    e.rd_rob_idx = rob;
    e.imm_sext   = 32'd4;
    e.memop      = st ? MemopStore : MemopLoad;
    e.mem_rmask  = st ? 4'h0 : 4'hf;
    e.mem_wmask  = st ? 4'hf : 4'h0;
    e.rs1        = '{ready: r1, tag: t1, data: d1};
    e.rs2        = '{ready: r2, tag: t2, data: d2};
    return e;
  endfunction

  task automatic push(input logic [31:0] pc, input logic st, input logic [31:0] r1,
                      input logic [31:0] r2, input int c);
    exp_t e;
    e = '{pc: pc, rs1: r1, rs2: r2, st: st, cyc: c};
    sb.push_back(e);
  endtask

  // Monitor: every issue pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && issue_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_issue: got issue of pc 0x%08h expected no issue (cycle %0d)",
                 issue_bundle.pc, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("issue_pc", issue_bundle.pc, e.pc);
        check("issue_rs1_data", issue_bundle.rs1_data, e.rs1);
        check("issue_rs2_data", issue_bundle.rs2_data, e.rs2);
        check("issue_memop", 32'(issue_bundle.memop), 32'(e.st));
        check("issue_bundle_valid", 32'(issue_bundle.valid), 32'd1);
        if (e.cyc >= 0) check("issue_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t;
    int n;
    int guard;

    // Reset
    repeat (3) step();
    rst = 1'b0;
    step();
    check("reset_issue_valid", 32'(issue_valid), 32'd0);
    check("reset_count", 32'(count), 32'd0);
    check("reset_enq_ready", 32'(enq_ready), 32'd1);
    check("reset_bundle_zero", 32'(issue_bundle != '0), 32'd0);

    // Load latency, bundle held during WAIT_LOAD, next pop with mem_done
    t = cyc;
    enq_valid = 1'b1;
    enq_entry = mk(32'h100, 1'b0, 1'b1, 5'd0, 32'h1000, 1'b1, 5'd0, 32'h0, 5'd1);
    push(32'h100, 1'b0, 32'h1000, 32'h0, t + 2);
    step();
    enq_entry = mk(32'h104, 1'b0, 1'b1, 5'd0, 32'h2000, 1'b1, 5'd0, 32'h0, 5'd2);
    push(32'h104, 1'b0, 32'h2000, 32'h0, t + 8);
    step();
    enq_valid = 1'b0;
    repeat (3) step();
    check("hold_bundle_pc", issue_bundle.pc, 32'h100);
    check("hold_bundle_rs1", issue_bundle.rs1_data, 32'h1000);
    check("hold_count", 32'(count), 32'd1);
    repeat (2) step();
    mem_done = 1'b1;
    step();
    mem_done = 1'b0;
    step();
    mem_done = 1'b1;
    step();
    mem_done = 1'b0;
    repeat (2) step();

    // Store waiting on rs2 from the CDB
    t = cyc;
    enq_valid = 1'b1;
    enq_entry = mk(32'h200, 1'b1, 1'b1, 5'd0, 32'h3000, 1'b0, 5'd3, 32'h0, 5'd7);
`ifdef MEM_ISSUE_QUEUE_STORE_COMMIT_EN
    push(32'h200, 1'b1, 32'h3000, 32'hDEAD_BEEF, t + 6);
`else
    push(32'h200, 1'b1, 32'h3000, 32'hDEAD_BEEF, t + 4);
`endif
    step();
    enq_valid = 1'b0;
    step();
    cdb_valid = 1'b1;
    cdb_rob_idx = 5'd3;
    cdb_data = 32'hDEAD_BEEF;
    step();
    cdb_valid = 1'b0;
`ifdef MEM_ISSUE_QUEUE_STORE_COMMIT_EN
    repeat (2) step();
    rob_head_idx = 5'd7;
    step();
    rob_head_idx = 5'd9;
`endif
    repeat (3) step();

    // Enqueue in the same cycle as the matching broadcast
    t = cyc;
    enq_valid = 1'b1;
    enq_entry = mk(32'h300, 1'b0, 1'b0, 5'd5, 32'h0, 1'b1, 5'd0, 32'h0, 5'd4);
    cdb_valid = 1'b1;
    cdb_rob_idx = 5'd5;
    cdb_data = 32'h5555;
    push(32'h300, 1'b0, 32'h5555, 32'h0, t + 2);
    step();
    enq_valid = 1'b0;
    cdb_valid = 1'b0;
    step();
    mem_done = 1'b1;
    step();
    mem_done = 1'b0;
    repeat (2) step();

    // Fill to capacity, then drain and refill across the pointer wrap
    for (int i = 0; i < 8; i++) begin
      enq_valid = 1'b1;
      enq_entry = mk(32'h400 + 32'(4 * i), 1'b1, 1'b0, 5'd10, 32'h0, 1'b1, 5'd0, 32'(i), 5'd9);
      push(32'h400 + 32'(4 * i), 1'b1, 32'hA0A0, 32'(i), -1);
      step();
    end
    check("full_count", 32'(count), 32'd8);
    check("full_enq_ready", 32'(enq_ready), 32'd0);
    enq_entry = mk(32'hBAD, 1'b1, 1'b1, 5'd0, 32'h0, 1'b1, 5'd0, 32'h0, 5'd9);
    step();
    enq_valid = 1'b0;
    check("full_no_overflow", 32'(count), 32'd8);
    cdb_valid = 1'b1;
    cdb_rob_idx = 5'd10;
    cdb_data = 32'hA0A0;
    step();
    cdb_valid = 1'b0;
    n = 8;
    guard = 0;
    while (n < 20 && guard < 200) begin
      guard++;
      if (enq_ready) begin
        enq_valid = 1'b1;
        enq_entry = mk(32'h400 + 32'(4 * n), 1'b1, 1'b1, 5'd0, 32'h1000 + 32'(n), 1'b1, 5'd0,
                       32'(n), 5'd9);
        push(32'h400 + 32'(4 * n), 1'b1, 32'h1000 + 32'(n), 32'(n), -1);
        n++;
      end else begin
        enq_valid = 1'b0;
      end
      step();
    end
    enq_valid = 1'b0;
    check("wrap_all_enqueued", 32'(n), 32'd20);
    guard = 0;
    while (count != 0 && guard < 100) begin
      guard++;
      step();
    end
    repeat (3) step();
    check("wrap_drained_count", 32'(count), 32'd0);
    check("wrap_scoreboard_empty", 32'(sb.size()), 32'd0);

    // Flush while a load is outstanding with five entries queued
    t = cyc;
    enq_valid = 1'b1;
    enq_entry = mk(32'h500, 1'b0, 1'b1, 5'd0, 32'h5000, 1'b1, 5'd0, 32'h0, 5'd11);
    push(32'h500, 1'b0, 32'h5000, 32'h0, t + 2);
    step();
    for (int i = 0; i < 5; i++) begin
      enq_entry = mk(32'h600 + 32'(4 * i), 1'b0, 1'b1, 5'd0, 32'h6000, 1'b1, 5'd0, 32'h0, 5'd12);
      step();
    end
    enq_valid = 1'b0;
    check("pre_flush_count", 32'(count), 32'd5);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_count", 32'(count), 32'd0);
    check("drain_enq_ready", 32'(enq_ready), 32'd0);
    check("drain_bundle_valid", 32'(issue_bundle.valid), 32'd1);
    check("drain_bundle_pc", issue_bundle.pc, 32'h500);
    repeat (2) step();
    check("drain_enq_ready_held", 32'(enq_ready), 32'd0);
    mem_done = 1'b1;
    step();
    mem_done = 1'b0;
    check("post_drain_enq_ready", 32'(enq_ready), 32'd1);
    repeat (4) step();
    check("post_drain_count", 32'(count), 32'd0);

    // Flush, enqueue and pop in one cycle
    enq_valid = 1'b1;
    enq_entry = mk(32'h700, 1'b1, 1'b1, 5'd0, 32'h7000, 1'b1, 5'd0, 32'h7, 5'd9);
    step();
    flush = 1'b1;
    enq_entry = mk(32'h704, 1'b1, 1'b1, 5'd0, 32'h7004, 1'b1, 5'd0, 32'h8, 5'd9);
    step();
    flush = 1'b0;
    enq_valid = 1'b0;
    check("flush_wins_count", 32'(count), 32'd0);
    check("flush_wins_no_issue", 32'(issue_valid), 32'd0);
    repeat (4) step();
    check("final_scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
